// File: rtl/fifo_pkg.sv
// Shared FIFO helpers and default parameters, common to the single- and dual-clock FIFOs.
package fifo_pkg;

  localparam int FIFO_DEPTH_DEF = 512;
  localparam int FIFO_WIDTH_DEF = 4;
  localparam int AE_THRESH_DEF  = 2;
  localparam int AF_MARGIN_DEF  = 2;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  // Pointers carry one extra wrap bit above the address bits.
  function automatic int ptr_width(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: one write port, one read address.
// SYNC_FIFO_FWFT_EN selects asynchronous read; otherwise read data is registered on i_re.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int WIDTH = FIFO_WIDTH_DEF,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign o_rdata = mem[i_raddr];

  logic unused_ctrl;
  assign unused_ctrl = &{1'b0, i_rst_n, i_clr, i_re};
`else
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  // Output register holds its value between accepted reads; flush zeroes it.
  always_comb begin
    rdata_d = rdata_q;
    if (i_clr) begin
      rdata_d = '0;
    end else if (i_re) begin
      rdata_d = mem[i_raddr];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign o_rdata = rdata_q;
`endif

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO: pointers, occupancy count, registered status flags and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int AF_THRESH  = FIFO_DEPTH - AF_MARGIN_DEF,
  parameter int AE_THRESH  = AE_THRESH_DEF,
  localparam int AW        = clog2(FIFO_DEPTH),
  localparam int PW        = ptr_width(FIFO_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_wen,
  input  logic [FIFO_WIDTH-1:0] i_wdata,
  input  logic                  i_ren,
  output logic [FIFO_WIDTH-1:0] o_rdata,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
  output logic [PW-1:0]         o_count,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam logic [PW-1:0] DEPTH_C = PW'(FIFO_DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_C    = PW'(AE_THRESH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          afull_q, afull_d;
  logic          aempty_q, aempty_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          wr_acc, rd_acc;
  logic [FIFO_WIDTH-1:0] mem_rdata;

  always_comb begin
    wr_acc   = i_wen && !full_q;
    rd_acc   = i_ren && !empty_q;
    ovf_d    = ovf_q || (i_wen && full_q);
    unf_d    = unf_q || (i_ren && empty_q);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Flush wins over any same-cycle request and leaves the array untouched.
    if (i_flush) begin
      wr_acc   = 1'b0;
      rd_acc   = 1'b0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PW'(wr_acc);
      rd_ptr_d = rd_ptr_q + PW'(rd_acc);
      count_d  = count_q + PW'(wr_acc) - PW'(rd_acc);
    end
    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AF_C);
    aempty_d = (count_d <= AE_C);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_mem #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_WIDTH)
  ) u_mem (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_flush),
    .i_we    (wr_acc),
    .i_waddr (wr_ptr_q[AW-1:0]),
    .i_wdata (i_wdata),
    .i_re    (rd_acc),
    .i_raddr (rd_ptr_q[AW-1:0]),
    .o_rdata (mem_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  assign o_rdata = empty_q ? '0 : mem_rdata;
`else
  assign o_rdata = mem_rdata;
`endif

  assign o_full         = full_q;
  assign o_empty        = empty_q;
  assign o_almost_full  = afull_q;
  assign o_almost_empty = aempty_q;
  assign o_count        = count_q;
  assign o_overflow     = ovf_q;
  assign o_underflow    = unf_q;

endmodule

// File: doc/sync_fifo_ctrl.md
# sync_fifo_ctrl

Single-clock, parametrised FIFO that succeeds the team's dual-clock FIFO for paths that do not cross a clock domain. It buffers FIFO_WIDTH-bit words in a FIFO_DEPTH-entry array and adds features the dual-clock FIFO lacks:
- occupancy count
- programmable almost-full / almost-empty thresholds
- sticky overflow/underflow error flags
- synchronous flush
- optional first-word-fall-through read mode

It sits between producer and consumer blocks in the same clock domain.

## Interface
- FIFO_DEPTH, 512, number of entries; power of 2, ≥ 4
- FIFO_WIDTH, 4, data word width in bits
- AF_THRESH, FIFO_DEPTH-2, o_almost_full asserts when count ≥ AF_THRESH
- AE_THRESH, 2, o_almost_empty asserts when count ≤ AE_THRESH
- i_clk  in  1  single clock; all logic on rising edge
- i_rst_n  in  1  reset, asynchronous and active-low
- i_flush  in  1  synchronous flush, priority over i_wen/i_ren
- i_wen  in  1  write request
- i_wdata  in  FIFO_WIDTH  write data
- i_ren  in  1  read request (pop in FWFT mode)
- o_rdata  out  FIFO_WIDTH  read data
- o_full / o_empty  out  1  status flags
- o_almost_full / o_almost_empty  out  1  threshold flags
- o_count  out  log2(FIFO_DEPTH)+1  words stored, 0..FIFO_DEPTH
- o_overflow / o_underflow  out  1  sticky error flags

## Operation
- Pointers are log2(FIFO_DEPTH)+1 bits wide; the MSB is the wrap bit.
  - Address = low bits.
  - Pointers wrap modulo 2·FIFO_DEPTH with no special-casing.
- Write accepted iff i_wen && !o_full; read accepted iff i_ren && !o_empty. Both flags are the registered values for the current cycle.
- Simultaneous accepted read and write: count unchanged, both pointers advance.
- At full with i_wen && i_ren: read accepted, write rejected, o_overflow sets, count becomes DEPTH-1.
- At empty with i_wen && i_ren: write accepted, read rejected, o_underflow sets, count becomes 1.
- Rejected write: o_overflow ← 1, sticky. Rejected read: o_underflow ← 1, sticky. Only reset or flush clears them.
- Flags are registered, derived from next-count:
  - o_full = (count == DEPTH)
  - o_empty = (count == 0)
  - o_almost_full = (count ≥ AF_THRESH)
  - o_almost_empty = (count ≤ AE_THRESH)
- i_flush: pointers and count go to 0, error flags clear, any i_wen/i_ren in the same cycle is ignored. Array contents are untouched.
- Reset (async assert, sync-release usage expected) and flush produce identical state:
  - o_count=0, o_empty=1, o_almost_empty=1
  - o_full=0, o_almost_full=0
  - o_overflow=0, o_underflow=0
  - o_rdata=0

## Timing
- Standard mode read latency: o_rdata is updated at the edge that accepts the read, so it is valid the cycle after i_ren is sampled. It holds its value when no read is accepted.
- Write-to-not-empty: a write accepted at edge N gives o_empty=0 after edge N.
- A flag or count change is visible one cycle after the causing edge; there is no combinational path from inputs to outputs.
- Reset asserted mid-transfer: all outputs go to reset values immediately (asynchronously). The in-flight write or read is lost.

## Configuration
- Macro SYNC_FIFO_FWFT_EN.
- Defined: first-word-fall-through. o_rdata = o_empty ? 0 : mem[rd_addr], combinational from the head entry. i_ren acknowledges and pops the displayed word. The head word is visible the cycle after its write, with no read latency.
- Undefined: standard registered read as in Timing.
- Flags, count and error behaviour are identical in both modes.

## Structure
- Package fifo_pkg holds:
  - the clog2 helper
  - the pointer-width derivation constant
  - default parameter constants, shared with the dual-clock FIFO
- One sub-module, fifo_mem: simple dual-port register array with one write port and one read address. Synchronous read data in standard mode; asynchronous read in FWFT mode, selected by the same macro.
- Control (pointers, count, flags, errors) lives in sync_fifo_ctrl.

## Test plan
All scenarios use FIFO_DEPTH=8, FIFO_WIDTH=4, AF_THRESH=6, AE_THRESH=2.
- Reset, then write 0x1..0x8 on 8 consecutive cycles → o_count 1..8, o_almost_empty falls when count reaches 3, o_almost_full rises when count reaches 6, o_full=1 after the 8th write.
- At full, pulse i_wen with 0xF → count stays 8, o_overflow=1. Then read 8 words → 0x1..0x8 in order, o_empty=1, o_overflow remains 1.
- At empty, pulse i_ren → o_underflow=1, o_rdata unchanged, count 0.
- Simultaneous i_wen/i_ren at count 4 for 20 cycles → count stays 4, data order preserved, pointers wrap with no corruption.
- With count 5 and both error flags set, assert i_flush with i_wen=1 → count 0, o_empty=1, both errors 0, nothing written.
- FWFT build: write 0xA at edge N → o_rdata=0xA and o_empty=0 after edge N. i_ren pops it → o_rdata=0 and o_empty=1 the next cycle.
